// File: rtl/countdown_master.sv
// Bus initiator for the shot-clock countdown: polls the timer toggle register, decrements on each
// toggle edge while running and writes the count in BCD to the display register.
module countdown_master #(
  parameter int unsigned INIT     = 24,
  parameter logic [31:0] DISP_ADR = 32'h0000FF00,
  parameter logic [31:0] TICK_ADR = 32'h0000FF01
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        pause,
  input  logic        reload,
  input  logic [31:0] io_data,
  output logic [31:0] adr,
  output logic [31:0] writedata,
  output logic        memwrite,
  output logic        running,
  output logic        expired
);

  localparam logic [6:0] InitCount = 7'(INIT);

  typedef enum logic [1:0] {
    StIdle0,
    StWrite,
    StPrime,
    StPoll
  } state_e;

  state_e     state_q, state_d;
  logic [6:0] count_q, count_d;
  logic       run_q, run_d;
  logic       wr_pend_q, wr_pend_d;
  logic       tick_prev_q, tick_prev_d;
  logic       primed_q, primed_d;

  logic       tick;
  logic       tick_evt;
  logic       dec;
  logic [3:0] tens;
  logic [3:0] ones;
  logic       unused_io_data;

  assign tick           = io_data[0];
  assign unused_io_data = ^io_data[31:1];

  // Reload wins over a simultaneous tick: the edge is consumed but not counted.
  assign tick_evt = (state_q == StPoll) && (tick != tick_prev_q);
  assign dec      = tick_evt && run_q && (count_q != 7'd0) && !reload;

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    run_d       = run_q;
    wr_pend_d   = wr_pend_q;
    tick_prev_d = tick_prev_q;
    primed_d    = primed_q;

    if (pause) begin
      run_d = 1'b0;
    end else if (start && (count_q != 7'd0)) begin
      run_d = 1'b1;
    end

    if (dec) begin
      count_d   = count_q - 7'd1;
      wr_pend_d = 1'b1;
      if (count_q == 7'd1) begin
        run_d = 1'b0;
      end
    end

    if (reload) begin
      count_d   = InitCount;
      wr_pend_d = 1'b1;
    end

    unique case (state_q)
      StIdle0: state_d = StWrite;
      StWrite: begin
        // A reload seen during a write queues another write straight after it.
        wr_pend_d = reload;
        if (reload) begin
          state_d = StWrite;
        end else if (!primed_q) begin
          state_d  = StPrime;
          primed_d = 1'b1;
        end else begin
          state_d = StPoll;
        end
      end
      StPrime: begin
        tick_prev_d = tick;
        state_d     = StPoll;
      end
      StPoll: begin
        tick_prev_d = tick;
        if (wr_pend_q || dec || reload) begin
          state_d = StWrite;
        end
      end
      default: state_d = StIdle0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle0;
      count_q     <= InitCount;
      run_q       <= 1'b0;
      wr_pend_q   <= 1'b1;
      tick_prev_q <= 1'b0;
      primed_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      run_q       <= run_d;
      wr_pend_q   <= wr_pend_d;
      tick_prev_q <= tick_prev_d;
      primed_q    <= primed_d;
    end
  end

  assign tens = 4'(count_q / 7'd10);
  assign ones = 4'(count_q % 7'd10);

  // Outputs are forced idle while reset is high so an in-flight write is abandoned.
  always_comb begin
    adr       = TICK_ADR;
    writedata = 32'd0;
    memwrite  = 1'b0;
    if (!reset && (state_q == StWrite)) begin
      adr       = DISP_ADR;
      writedata = {24'd0, tens, ones};
      memwrite  = 1'b1;
    end
  end

  assign running = run_q && !reset;
  assign expired = (count_q == 7'd0) && !reset;

endmodule

// File: tb/tb_countdown_master.sv
// Randomised and directed bench for countdown_master with a cycle-level behavioural model of the
// countdown, a toggling timer register and a display register that logs every committed write.
module tb_countdown_master;

  localparam int unsigned Init    = 24;
  localparam logic [31:0] DispAdr = 32'h0000FF00;
  localparam logic [31:0] TickAdr = 32'h0000FF01;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        pause;
  logic        reload;
  logic [31:0] io_data;
  logic [31:0] adr;
  logic [31:0] writedata;
  logic        memwrite;
  logic        running;
  logic        expired;

  logic        toggle;
  logic [7:0]  wr_log[$];
  int          num_checks = 0;
  int          num_fails  = 0;
  int          base;

  bit          auto_tog   = 1'b0;
  bit          tog_rand   = 1'b0;
  int          tog_period = 10;
  int          tog_ctr    = 0;

  // Reference model of the countdown, in plain integers and flags.
  int m_count = Init;
  bit m_run, m_pend, m_prev, m_first, m_wr, m_prime, m_poll;

  always #5 clk = ~clk;

  assign io_data = (adr == TickAdr) ? {31'd0, toggle} : 32'd0;

  countdown_master #(
    .INIT    (Init),
    .DISP_ADR(DispAdr),
    .TICK_ADR(TickAdr)
  ) u_dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .pause    (pause),
    .reload   (reload),
    .io_data  (io_data),
    .adr      (adr),
    .writedata(writedata),
    .memwrite (memwrite),
    .running  (running),
    .expired  (expired)
  );

  always @(posedge clk) begin
    if (memwrite === 1'b1 && adr == DispAdr) wr_log.push_back(writedata[7:0]);
  end

  function automatic logic [7:0] bcd(input int c);
    return 8'(((c / 10) << 4) | (c % 10));
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    num_checks++;
    if (got !== exp) begin
      num_fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] log_at(input int idx);
    if (idx < 0 || idx >= wr_log.size()) return 32'hDEAD_BEEF;
    return 32'(wr_log[idx]);
  endfunction

  // One bus cycle: compare outputs against the model mid-cycle, then advance the model.
  task automatic cyc();
    bit e_mw, e_run, e_exp, idle, evt, dec;
    int n_count;
    bit n_run, n_pend, n_prev, n_first, n_wr, n_prime, n_poll;
    @(negedge clk);
    e_mw  = !reset && m_wr;
    e_run = !reset && m_run;
    e_exp = !reset && (m_count == 0);
    check_eq("memwrite", 32'(memwrite), 32'(e_mw));
    check_eq("adr", adr, e_mw ? DispAdr : TickAdr);
    check_eq("writedata", writedata, e_mw ? {24'd0, bcd(m_count)} : 32'd0);
    check_eq("running", 32'(running), 32'(e_run));
    check_eq("expired", 32'(expired), 32'(e_exp));
    if (reset) begin
      n_count = Init; n_run = 0; n_pend = 1; n_prev = 0; n_first = 1;
      n_wr = 0; n_prime = 0; n_poll = 0;
    end else begin
      idle    = !m_wr && !m_prime && !m_poll;
      evt     = m_poll && (toggle != m_prev);
      dec     = evt && m_run && (m_count > 0) && !reload;
      n_count = reload ? Init : (dec ? m_count - 1 : m_count);
      n_run   = pause ? 1'b0 : ((start && m_count != 0) ? 1'b1 : m_run);
      if (dec && m_count == 1) n_run = 0;
      n_pend  = m_wr ? reload : (m_pend || dec || reload);
      n_prev  = (m_prime || m_poll) ? toggle : m_prev;
      n_first = m_first;
      n_wr = 0; n_prime = 0; n_poll = 0;
      if (idle) begin
        n_wr = 1;
      end else if (m_wr) begin
        if (reload) n_wr = 1;
        else if (m_first) begin n_prime = 1; n_first = 0; end
        else n_poll = 1;
      end else if (m_prime) begin
        n_poll = 1;
      end else begin
        n_wr   = m_pend || dec || reload;
        n_poll = !n_wr;
      end
    end
    @(posedge clk);
    #1;
    m_count = n_count; m_run = n_run; m_pend = n_pend; m_prev = n_prev; m_first = n_first;
    m_wr = n_wr; m_prime = n_prime; m_poll = n_poll;
    if (auto_tog) begin
      tog_ctr++;
      if (tog_ctr >= tog_period) begin
        toggle  = ~toggle;
        tog_ctr = 0;
        if (tog_rand) tog_period = $urandom_range(5, 15);
      end
    end
  endtask

  task automatic run(input int n);
    repeat (n) cyc();
  endtask

  task automatic flip_wait(input int n);
    toggle = ~toggle;
    run(n);
  endtask

  initial begin
    reset = 1; start = 0; pause = 0; reload = 0; toggle = 0;
    run(3);
    reset = 0;

    // Idle after reset: one display write of INIT, nothing more without start.
    base = wr_log.size();
    auto_tog = 1;
    run(40);
    auto_tog = 0;
    check_eq("init_wr_cnt", 32'(wr_log.size() - base), 32'd1);
    check_eq("init_wr_val", log_at(base), 32'h24);
    check_eq("idle_running", 32'(running), 32'd0);

    // Start and three toggles.
    base = wr_log.size();
    start = 1; cyc(); start = 0;
    run(2);
    repeat (3) flip_wait(8);
    check_eq("run3_cnt", 32'(wr_log.size() - base), 32'd3);
    check_eq("run3_v0", log_at(base), 32'h23);
    check_eq("run3_v1", log_at(base + 1), 32'h22);
    check_eq("run3_v2", log_at(base + 2), 32'h21);
    check_eq("run3_running", 32'(running), 32'd1);

    // Drain to zero, then an extra toggle and start must do nothing.
    base = wr_log.size();
    repeat (21) flip_wait(6);
    check_eq("drain_cnt", 32'(wr_log.size() - base), 32'd21);
    check_eq("drain_last", log_at(wr_log.size() - 1), 32'h00);
    check_eq("zero_expired", 32'(expired), 32'd1);
    check_eq("zero_running", 32'(running), 32'd0);
    base = wr_log.size();
    flip_wait(6);
    start = 1; cyc(); start = 0;
    run(5);
    flip_wait(6);
    check_eq("zero_nowrite", 32'(wr_log.size() - base), 32'd0);
    check_eq("zero_start_ign", 32'(running), 32'd0);

    // Reload, run to 20, pause across five toggles, resume.
    base = wr_log.size();
    reload = 1; cyc(); reload = 0;
    run(5);
    start = 1; cyc(); start = 0;
    repeat (4) flip_wait(6);
    check_eq("reload_v", log_at(base), 32'h24);
    check_eq("to20_v", log_at(base + 4), 32'h20);
    pause = 1; cyc(); pause = 0;
    base = wr_log.size();
    repeat (5) flip_wait(6);
    check_eq("paused_nowrite", 32'(wr_log.size() - base), 32'd0);
    check_eq("paused_running", 32'(running), 32'd0);
    start = 1; cyc(); start = 0;
    run(2);
    flip_wait(6);
    check_eq("resume_cnt", 32'(wr_log.size() - base), 32'd1);
    check_eq("resume_v", log_at(base), 32'h19);

    // Reload on a tick edge at 15; then reload during a write.
    repeat (4) flip_wait(6);
    base = wr_log.size();
    toggle = ~toggle; reload = 1; cyc(); reload = 0;
    run(6);
    check_eq("rl_tick_cnt", 32'(wr_log.size() - base), 32'd1);
    check_eq("rl_tick_v", log_at(base), 32'h24);
    base = wr_log.size();
    flip_wait(6);
    toggle = ~toggle; cyc();
    reload = 1; cyc(); reload = 0;
    run(6);
    check_eq("rl_wr_cnt", 32'(wr_log.size() - base), 32'd3);
    check_eq("rl_wr_v0", log_at(base), 32'h23);
    check_eq("rl_wr_v1", log_at(base + 1), 32'h22);
    check_eq("rl_wr_v2", log_at(base + 2), 32'h24);

    // Reset during the write of 9.
    repeat (14) flip_wait(6);
    base = wr_log.size();
    toggle = ~toggle; cyc();
    reset = 1; cyc(); reset = 0;
    run(8);
    check_eq("rst_wr_cnt", 32'(wr_log.size() - base), 32'd1);
    check_eq("rst_wr_v", log_at(base), 32'h24);
    check_eq("rst_running", 32'(running), 32'd0);

    // Random control traffic against the model.
    auto_tog = 1; tog_rand = 1;
    repeat (3000) begin
      start  = ($urandom_range(0, 99) < 5);
      pause  = ($urandom_range(0, 99) < 2);
      reload = ($urandom_range(0, 99) < 2);
      reset  = ($urandom_range(0, 999) < 3);
      cyc();
    end
    start = 0; pause = 0; reload = 0; reset = 0;
    run(10);

    $display("TB_RESULT checks=%0d failures=%0d", num_checks, num_fails);
    $finish;
  end

endmodule
